dshot_frame_tx: RTL

- Serialises one DShot command frame (11-bit throttle, telemetry bit, 4-bit CRC; 16 bits, MSB first) onto the ESC signal line.
- Sits directly downstream of the baud-rate divider.
  - Drives the divider's enable input.
  - Consumes its bit tick, half-phase and quarter-phase levels to shape each bit's pulse width.
- Upstream command logic hands frames in over a valid/ready handshake.

---
 rtl/dshot_frame_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dshot_frame_tx.sv
// dshot_frame_tx
//   Serialises one 16-bit DShot frame onto the ESC line. The frame is the
//   11-bit throttle, the telemetry bit and a 4-bit CRC, sent MSB first. Each
//   bit's pulse width comes from the baud divider's half- and quarter-phase
//   levels. The divider runs only while baud_en is high, and its counter is
//   held at 0 while baud_en is low. After the 16th bit the line stays low for
//   GAP_BITS bit periods. frame_done then pulses and the block returns to IDLE.
//
//   Build option: define DSHOT_INVERT_EN for bidirectional (inverted) DShot.
//   This inverts the CRC and the whole line polarity, so the line idles high.
//
// Ports
//   clk_in        system clock
//   reset         synchronous, active-high
//   cmd_valid     command present
//   cmd_ready     command can be accepted (IDLE only)
//   cmd_throttle  11-bit DShot value
//   cmd_telem     telemetry request bit
//   baud_en       enable to the baud divider
//   bit_tick      last clock of each bit period
//   half_phase    second half of a bit period
//   quarter_phase 2nd and 4th quarter of a bit period
//   dshot_out     registered ESC signal
//   busy          high while sending or in the inter-frame gap
//   frame_done    one-cycle pulse when the gap ends
module dshot_frame_tx #(
    parameter int unsigned GAP_BITS = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_throttle,
    input  logic        cmd_telem,
    output logic        baud_en,
    input  logic        bit_tick,
    input  logic        half_phase,
    input  logic        quarter_phase,
    output logic        dshot_out,
    output logic        busy,
    output logic        frame_done
);

`ifdef DSHOT_INVERT_EN
    localparam logic IDLE_LEVEL = 1'b1;
`else
    localparam logic IDLE_LEVEL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [3:0]  gap_cnt, gap_cnt_nxt;
    logic        line_nxt;        // non-inverted line level for the next cycle
    logic        frame_done_nxt;
    logic        dshot_q;

    function automatic logic [15:0] build_frame(input logic [10:0] thr,
                                                input logic        telem);
        logic [11:0] v;
        logic [3:0]  crc;
        v   = {thr, telem};
        crc = v[3:0] ^ v[7:4] ^ v[11:8];
`ifdef DSHOT_INVERT_EN
        crc = ~crc;
`endif
        return {v, crc};
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dshot_q    <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            dshot_q    <= line_nxt ^ IDLE_LEVEL;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        gap_cnt_nxt    = gap_cnt;
        line_nxt       = 1'b0;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt   = SEND;
                    shreg_nxt   = build_frame(cmd_throttle, cmd_telem);
                    bit_cnt_nxt = 4'd15;
                end
            end

            SEND: begin
                // A '1' bit is high except in the 4th quarter.
                // A '0' bit is high only in the 1st quarter.
                if (shreg[15])
                    line_nxt = !(half_phase && quarter_phase);
                else
                    line_nxt = !half_phase && !quarter_phase;

                if (bit_tick) begin
                    if (bit_cnt != 4'd0) begin
                        shreg_nxt   = {shreg[14:0], 1'b0};
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = 4'(GAP_BITS - 1);
                        line_nxt    = 1'b0;
                    end
                end
            end

            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt_nxt = gap_cnt - 4'd1;
                    end else begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign baud_en   = (state != IDLE);
    assign busy      = (state != IDLE);
    assign dshot_out = dshot_q;

endmodule
